// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = $clog2(DEF_WIDTH);
  localparam logic [DEF_WIDTH-1:0] ERR_QUOT = '1;

  // A 1-bit counter is still needed when WIDTH==1 ($clog2 gives 0).
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Request/response bundle for seq_divider: valid/ready in, valid/ready out.
interface seq_divider_if #(parameter int WIDTH = 4);
  logic               in_valid;
  logic               in_ready;
  logic [2*WIDTH-1:0] dividend;
  logic [WIDTH-1:0]   divisor;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   quotient;
  logic [WIDTH-1:0]   remainder;
  logic               div_zero;
  logic               overflow;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_zero, overflow
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_zero, overflow
  );
endinterface

// File: rtl/seq_divider_step.sv
// One combinational restoring-division iteration: shift in a dividend bit,
// trial-subtract the divisor, keep the difference if it did not go negative.
module div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   r,
  input  logic             nbit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   r_nxt,
  output logic             q_bit
);
  // r[WIDTH] is always 0 between steps (r < divisor); widening keeps it harmless.
  logic [WIDTH+1:0] t;
  logic [WIDTH+1:0] diff;

  always_comb begin
    t     = {r, nbit};
    diff  = t - {2'b00, divisor};
    q_bit = (t >= {2'b00, divisor});
    r_nxt = q_bit ? diff[WIDTH:0] : t[WIDTH:0];
  end
endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: 2W/W unsigned, one quotient bit per clock.
// Optional divisor==1 bypass enabled by SEQ_DIVIDER_FAST_PATH_EN.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input logic          clk,
  input logic          rst_n,
  seq_divider_if.slave bus
);
  localparam int CW = cnt_width(WIDTH);
  localparam logic [WIDTH-1:0] ERR_Q = '1;

  state_e            state_q, state_d;
  logic [WIDTH:0]    r_q, r_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic [WIDTH-1:0]  qacc_q, qacc_d;
  logic [WIDTH-1:0]  dvs_q, dvs_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  quo_q, quo_d;
  logic [WIDTH-1:0]  rem_q, rem_d;
  logic              dz_q, dz_d;
  logic              ov_q, ov_d;

  logic [WIDTH:0]    r_nxt;
  logic              q_bit;
  logic              fast;
  logic [WIDTH-1:0]  q_fin;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r       (r_q),
    .nbit    (lo_q[WIDTH-1]),
    .divisor (dvs_q),
    .r_nxt   (r_nxt),
    .q_bit   (q_bit)
  );

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    lo_d    = lo_q;
    qacc_d  = qacc_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    ov_d    = ov_q;
    fast    = 1'b0;
`ifdef SEQ_DIVIDER_FAST_PATH_EN
    fast    = (bus.divisor == WIDTH'(1));
`endif
    q_fin   = WIDTH'({qacc_q, q_bit});

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          dz_d = 1'b0;
          ov_d = 1'b0;
          if (bus.divisor == '0) begin
            dz_d    = 1'b1;
            quo_d   = ERR_Q;
            rem_d   = bus.dividend[WIDTH-1:0];
            state_d = DONE;
          end else if (bus.dividend[2*WIDTH-1:WIDTH] >= bus.divisor) begin
            ov_d    = 1'b1;
            quo_d   = ERR_Q;
            rem_d   = '0;
            state_d = DONE;
          end else if (fast) begin
            quo_d   = bus.dividend[WIDTH-1:0];
            rem_d   = '0;
            state_d = DONE;
          end else begin
            r_d     = {1'b0, bus.dividend[2*WIDTH-1:WIDTH]};
            lo_d    = bus.dividend[WIDTH-1:0];
            dvs_d   = bus.divisor;
            qacc_d  = '0;
            cnt_d   = CW'(WIDTH-1);
            state_d = RUN;
          end
        end
      end
      RUN: begin
        r_d    = r_nxt;
        lo_d   = WIDTH'({lo_q, 1'b0});
        qacc_d = q_fin;
        cnt_d  = cnt_q - 1'b1;
        // Results land in the output registers only on the final step.
        if (cnt_q == '0) begin
          quo_d   = q_fin;
          rem_d   = r_nxt[WIDTH-1:0];
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      lo_q    <= '0;
      qacc_q  <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      lo_q    <= lo_d;
      qacc_q  <= qacc_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      ov_q    <= ov_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
  assign bus.div_zero  = dz_q;
  assign bus.overflow  = ov_q;
endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (WIDTH=4).
module tb_seq_divider;
  localparam int W = 4;
`ifdef SEQ_DIVIDER_FAST_PATH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  seq_divider_if #(.WIDTH(W)) bus();
  seq_divider #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // {out_valid, in_ready, quotient, remainder, div_zero, overflow}
  function automatic logic [11:0] obs();
    return {bus.out_valid, bus.in_ready, bus.quotient, bus.remainder, bus.div_zero, bus.overflow};
  endfunction

  // Present one request for a single edge; returns #1 after that edge.
  task automatic issue(input logic [7:0] dvd, input logic [3:0] dvs);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.dividend = dvd;
    bus.divisor  = dvs;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Counts edges until out_valid, bounded at 20.
  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic drain();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_chk++;
    if (obs() !== 12'b0_1_0000_0000_0_0) begin
      n_fail++; $display("FAIL reset_state got=%h want=%h", obs(), 12'b0_1_0000_0000_0_0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (obs() !== 12'b0_1_0000_0000_0_0) begin
      n_fail++; $display("FAIL post_reset_idle got=%h want=%h", obs(), 12'b0_1_0000_0000_0_0);
    end
  endtask

  task automatic test_normal();
    int n;
    bus.out_ready = 1'b1;
    issue(8'd100, 4'd7);
    repeat (W-1) @(posedge clk);
    #1;
    n_chk++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL normal_early_valid got=%b want=0", bus.out_valid);
    end
    wait_valid(n);
    n_chk++;
    if (obs() !== {1'b1, 1'b0, 4'd14, 4'd2, 1'b0, 1'b0} || n != 1) begin
      n_fail++; $display("FAIL normal_100_7 got=%h edges=%0d want=%h edges=1", obs(), n, {1'b1, 1'b0, 4'd14, 4'd2, 2'b00});
    end
    @(posedge clk); #1;
    n_chk++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL normal_back_idle got=%b want=01", {bus.out_valid, bus.in_ready});
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_div_zero();
    issue(8'd45, 4'd0);
    n_chk++;
    if (obs() !== {1'b1, 1'b0, 4'hF, 4'hD, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL div_zero_45_0 got=%h want=%h", obs(), {1'b1, 1'b0, 4'hF, 4'hD, 2'b10});
    end
    drain();
  endtask

  task automatic test_overflow();
    issue(8'd200, 4'd3);
    n_chk++;
    if (obs() !== {1'b1, 1'b0, 4'hF, 4'h0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL overflow_200_3 got=%h want=%h", obs(), {1'b1, 1'b0, 4'hF, 4'h0, 2'b01});
    end
    drain();
    issue(8'd255, 4'd15);
    n_chk++;
    if (obs() !== {1'b1, 1'b0, 4'hF, 4'h0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL overflow_255_15 got=%h want=%h", obs(), {1'b1, 1'b0, 4'hF, 4'h0, 2'b01});
    end
    drain();
  endtask

  task automatic test_back_pressure();
    int n;
    issue(8'd100, 4'd7);
    wait_valid(n);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = (i == 2);
      bus.dividend = 8'd9;
      bus.divisor  = 4'd2;
      @(posedge clk); #1;
      n_chk++;
      if (obs() !== {1'b1, 1'b0, 4'd14, 4'd2, 1'b0, 1'b0}) begin
        n_fail++; $display("FAIL hold_cycle%0d got=%h want=%h", i, obs(), {1'b1, 1'b0, 4'd14, 4'd2, 2'b00});
      end
    end
    bus.in_valid = 1'b0;
    drain();
    n_chk++;
    if (obs() !== {1'b0, 1'b1, 4'd14, 4'd2, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL release_idle got=%h want=%h", obs(), {1'b0, 1'b1, 4'd14, 4'd2, 2'b00});
    end
    issue(8'd9, 4'd2);
    wait_valid(n);
    n_chk++;
    if (obs() !== {1'b1, 1'b0, 4'd4, 4'd1, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL after_hold_9_2 got=%h want=%h", obs(), {1'b1, 1'b0, 4'd4, 4'd1, 2'b00});
    end
    drain();
  endtask

  task automatic test_reset_mid_run();
    int n;
    issue(8'd100, 4'd7);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (obs() !== 12'b0_1_0000_0000_0_0) begin
      n_fail++; $display("FAIL reset_mid_run got=%h want=%h", obs(), 12'b0_1_0000_0000_0_0);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    n_chk++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_no_partial got=%b want=0", bus.out_valid);
    end
    issue(8'd100, 4'd7);
    wait_valid(n);
    n_chk++;
    if (obs() !== {1'b1, 1'b0, 4'd14, 4'd2, 1'b0, 1'b0} || n != W) begin
      n_fail++; $display("FAIL rerun_100_7 got=%h edges=%0d want=%h edges=%0d", obs(), n, {1'b1, 1'b0, 4'd14, 4'd2, 2'b00}, W);
    end
    drain();
  endtask

  task automatic test_exhaustive();
    int n;
    int lat;
    logic err;
    logic [11:0] want;
    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        err  = ((a >> 4) >= b);
        lat  = (err || (FAST && b == 1)) ? 0 : W;
        want = err ? {1'b1, 1'b0, 4'hF, 4'h0, 1'b0, 1'b1}
                   : {1'b1, 1'b0, 4'(a / b), 4'(a % b), 1'b0, 1'b0};
        issue(8'(a), 4'(b));
        wait_valid(n);
        n_chk++;
        if (obs() !== want || n != lat) begin
          n_fail++;
          $display("FAIL exh_%0d_%0d got=%h edges=%0d want=%h edges=%0d", a, b, obs(), n, want, lat);
        end
        if (!err) begin
          n_chk++;
          if (int'(bus.quotient) * b + int'(bus.remainder) != a || int'(bus.remainder) >= b) begin
            n_fail++;
            $display("FAIL invariant_%0d_%0d q=%0d r=%0d", a, b, bus.quotient, bus.remainder);
          end
        end
        drain();
      end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_normal();
    test_div_zero();
    test_overflow();
    test_back_pressure();
    test_reset_mid_run();
    test_exhaustive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential restoring divider and the inverse of the team's 4x4 array multiplier.
- Divides a 2*WIDTH-bit dividend by a WIDTH-bit divisor and returns a WIDTH-bit quotient and a WIDTH-bit remainder.
- Produces one quotient bit per clock.
- Uses valid/ready handshakes on input and output so it can sit directly downstream of product-generating datapaths.

Parameters:
WIDTH, 4, divisor/quotient/remainder width; dividend is 2*WIDTH bits

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  dividend/divisor presented
in_ready  output  1  block can accept a request (high only in IDLE)
dividend  input  2*WIDTH  numerator, sampled on accept
divisor  input  WIDTH  denominator, sampled on accept
out_valid  output  1  result available
out_ready  input  1  consumer takes result
quotient  output  WIDTH  result quotient
remainder  output  WIDTH  result remainder
div_zero  output  1  divisor was 0
overflow  output  1  quotient would not fit in WIDTH bits

Behaviour:
- Reset: one clock domain; asynchronous, active-low reset (rst_n) forces state=IDLE.
  - quotient, remainder, div_zero, overflow and out_valid reset to 0; in_ready is 1 out of reset.
  - Assertion mid-operation aborts immediately; no partial result is ever presented.
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. Accept on in_valid&&in_ready.
  - divisor==0 -> DONE next edge; div_zero=1, quotient=all ones, remainder=dividend[WIDTH-1:0].
  - else if dividend[2W-1:W] >= divisor -> DONE next edge; overflow=1, quotient=all ones, remainder=0.
  - else load partial remainder R (WIDTH+1 bits) = {0, dividend[2W-1:W]}, low shift register = dividend[W-1:0], iteration counter = WIDTH-1 -> RUN.
- RUN: each edge performs one restoring step.
  - T = {R[W-1:0], next dividend bit (MSB first)}.
  - If T >= {0,divisor}: R = T-divisor, shift in quotient bit 1; else R = T, shift in 0.
  - Counter decrements; the step with counter==0 transitions to DONE.
- Latency: normal case out_valid rises exactly WIDTH edges after the accepting edge; error cases 1 edge after.
- DONE: out_valid=1, in_ready=0.
  - quotient, remainder and flags hold stable until out_ready=1.
  - On out_valid&&out_ready -> IDLE and out_valid drops next edge.
  - Flags are cleared when the next request is accepted.
- Throughput: no back-to-back overlap, so one result per WIDTH+2 cycles minimum with out_ready tied high.
- Inputs may change or in_valid may toggle during RUN/DONE; these are ignored and only acceptance-edge values matter.
- Invariant for non-error results: quotient*divisor + remainder == dividend, with remainder < divisor.
- Arithmetic is unsigned only. The compare/subtract is WIDTH+1 bits wide so the shifted-out MSB is never lost.

Optional Feature:
- Macro: SEQ_DIVIDER_FAST_PATH_EN.
- Defined: on accept with divisor==1 and no error, go directly to DONE on the next edge with quotient=dividend[W-1:0], remainder=0. The bypass is 1-edge latency; all other cases are unchanged.
- Undefined: divisor==1 takes the normal WIDTH-edge iterative path. Results are identical either way; only latency differs.

Decomposition:
- Shared package seq_divider_pkg holds:
  - state typedef (IDLE/RUN/DONE encoding);
  - width-derived localparam for counter width, $clog2(WIDTH);
  - error-case quotient constant (all ones).
- One natural sub-module: div_step, a purely combinational single restoring iteration.
  - Inputs: R, next bit, divisor. Outputs: new R, quotient bit.
  - Instantiated once in seq_divider.

Test Plan (WIDTH=4):
- 100/7 accepted, out_ready=1 -> after 4 edges out_valid=1, quotient=14, remainder=2, div_zero=0, overflow=0; IDLE next edge.
- 45/0 -> 1 edge later out_valid=1, div_zero=1, quotient=4'hF, remainder=4'hD.
- 200/3 (upper nibble 12>=3) -> 1 edge later overflow=1, quotient=4'hF, remainder=0; 255/15 -> overflow=1.
- 100/7 with out_ready low for 5 cycles and in_valid pulsed with 9/2 meanwhile -> results stay stable, in_ready=0, 9/2 not accepted; release out_ready -> IDLE, then 9/2 yields quotient 4, remainder 1.
- Assert rst_n low during RUN of 100/7 -> immediately out_valid=0, all outputs 0, in_ready=1; a fresh 100/7 afterwards completes correctly.
- Exhaustive: for all a,b in 1..15, dividend=a*b, divisor=b -> quotient=a, remainder=0. For all 256 dividends x 15 divisors, non-error results satisfy the invariant; latency is 4 edges (1 edge for divisor==1 when SEQ_DIVIDER_FAST_PATH_EN is defined).
